autotype_sequencer: RTL and testbench

AUTOTYPE_SEQUENCER -- requirements
Module: autotype_sequencer

---
 rtl/autotype_sequencer.sv | 159 +++++++++++++++
 tb/tb_autotype_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/autotype_sequencer.sv
// Scripted key-press sequencer: plays SCRIPT one step at a time as PRESS/GAP windows on a one-hot key bus.
// Optional macro AUTOTYPE_REPEAT_EN: the script loops from step 0 after every END cycle.
module autotype_sequencer #(
  parameter int                   KEYS         = 8,
  parameter int                   STEPS        = 8,
  parameter logic [STEPS*8-1:0]   SCRIPT       = {STEPS{8'hFF}},
  parameter int                   PRESS_CYCLES = 2**24,
  parameter int                   GAP_CYCLES   = 2**24,
  parameter int                   AUTOSTART    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  output logic [KEYS-1:0] key,
  output logic            target_n_reset,
  output logic            busy,
  output logic            done
);

  localparam int MAX_CYC = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int IDX_W   = $clog2(STEPS + 1);
  localparam int MEM_N   = 2**IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP, S_END} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [KEYS-1:0]  key_reg, key_next;
  logic             tnr_reg, tnr_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             auto_reg;
  logic             launch;

  // Entries past the script read as 8'hFF, so running off the end behaves like an end code.
  logic [7:0] script_mem [MEM_N];
  genvar gi;
  generate
    for (gi = 0; gi < MEM_N; gi++) begin : g_mem
      if (gi < STEPS) begin : g_step
        assign script_mem[gi] = SCRIPT[8*gi +: 8];
      end else begin : g_pad
        assign script_mem[gi] = 8'hFF;
      end
    end
  endgenerate

  // Step about to be entered: the next one when leaving GAP, otherwise step 0.
  logic [IDX_W-1:0] launch_idx;
  logic [7:0]       launch_code;
  logic [KEYS-1:0]  key_dec;

  assign launch_idx  = (state_reg == S_GAP) ? idx_reg + IDX_W'(1) : '0;
  assign launch_code = script_mem[launch_idx];

  generate
    for (gi = 0; gi < KEYS; gi++) begin : g_dec
      assign key_dec[gi] = (launch_code == 8'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    key_next   = '0;
    tnr_next   = 1'b1;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    launch     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start || auto_reg) launch = 1'b1;
      end
      S_PRESS: begin
        busy_next = 1'b1;
        if (cnt_reg == '0) begin
          state_next = S_GAP;
          cnt_next   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
          key_next = key_reg;
          tnr_next = tnr_reg;
        end
      end
      S_GAP: begin
        if (cnt_reg == '0) begin
          launch = 1'b1;
        end else begin
          busy_next = 1'b1;
          cnt_next  = cnt_reg - CNT_W'(1);
        end
      end
      S_END: begin
`ifdef AUTOTYPE_REPEAT_EN
        launch = 1'b1;
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase

    if (launch) begin
      idx_next = launch_idx;
      if (launch_code == 8'hFF) begin
        state_next = S_END;
        done_next  = 1'b1;
      end else begin
        state_next = S_PRESS;
        cnt_next   = CNT_W'(PRESS_CYCLES - 1);
        busy_next  = 1'b1;
        key_next   = key_dec;
        tnr_next   = (launch_code != 8'hFE);
      end
    end

    if (abort) begin
      state_next = S_IDLE;
      idx_next   = '0;
      key_next   = '0;
      tnr_next   = 1'b1;
      busy_next  = 1'b0;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      key_reg   <= '0;
      tnr_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      auto_reg  <= (AUTOSTART != 0);
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      key_reg   <= key_next;
      tnr_reg   <= tnr_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      auto_reg  <= 1'b0;
    end
  end

  assign key            = key_reg;
  assign target_n_reset = tnr_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;

endmodule

// File: tb/tb_autotype_sequencer.sv
// Table-driven bench: each record is one clock of inputs plus the outputs expected after that edge.
module tb_autotype_sequencer;
  localparam int P = 4;
  localparam int G = 2;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] key_a, key_b;
  logic       tnr_a, busy_a, done_a, tnr_b, busy_b, done_b;

  autotype_sequencer #(.KEYS(8), .STEPS(4), .SCRIPT({8'hFF, 8'h03, 8'h01, 8'hFE}),
    .PRESS_CYCLES(P), .GAP_CYCLES(G), .AUTOSTART(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .key(key_a), .target_n_reset(tnr_a), .busy(busy_a), .done(done_a));

  autotype_sequencer #(.KEYS(8), .STEPS(2), .SCRIPT({8'h09, 8'h00}),
    .PRESS_CYCLES(P), .GAP_CYCLES(G), .AUTOSTART(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .key(key_b), .target_n_reset(tnr_b), .busy(busy_b), .done(done_b));

`ifdef AUTOTYPE_REPEAT_EN
  logic [7:0] key_c;
  logic       tnr_c, busy_c, done_c;
  autotype_sequencer #(.KEYS(8), .STEPS(2), .SCRIPT({8'hFF, 8'h02}),
    .PRESS_CYCLES(P), .GAP_CYCLES(G), .AUTOSTART(1)) dut_c (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .key(key_c), .target_n_reset(tnr_c), .busy(busy_c), .done(done_c));
`endif

  typedef struct {
    int         sel;
    logic       rst, st, ab;
    logic [7:0] key;
    logic       tnr, busy, done;
    string      name;
  } vec_t;

  vec_t table_q[$];
  vec_t sb[$];
  int passed = 0;
  int total  = 0;

  function automatic void add(int n, string name, int sel, logic rst, logic st, logic ab,
                              logic [7:0] k, logic t, logic b, logic d);
    for (int i = 0; i < n; i++) table_q.push_back('{sel, rst, st, ab, k, t, b, d, name});
  endfunction

  always @(posedge clk) begin : monitor
    vec_t e;
    logic [7:0] k;
    logic t, b, d;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       begin k = key_a; t = tnr_a; b = busy_a; d = done_a; end
        1:       begin k = key_b; t = tnr_b; b = busy_b; d = done_b; end
`ifdef AUTOTYPE_REPEAT_EN
        default: begin k = key_c; t = tnr_c; b = busy_c; d = done_c; end
`else
        default: begin k = 'x; t = 'x; b = 'x; d = 'x; end
`endif
      endcase
      total++;
      if ({k, t, b, d} === {e.key, e.tnr, e.busy, e.done}) passed++;
      else $display("FAIL %s: got key=%h tnr=%b busy=%b done=%b, want key=%h tnr=%b busy=%b done=%b",
                    e.name, k, t, b, d, e.key, e.tnr, e.busy, e.done);
      total++;
      if ($onehot0(k) && !((k != 8'h00) && (t == 1'b0))) passed++;
      else $display("FAIL %s_invariant: key=%h tnr=%b, want one-hot-or-zero key never with tnr low",
                    e.name, k, t);
    end
  end

  initial begin
`ifndef AUTOTYPE_REPEAT_EN
    // Autostart script {FE,1,3,FF}: done lands 3*(P+G) cycles after the first PRESS cycle.
    add(3, "reset_hold", 0, 1, 0, 0, 8'h00, 0, 0, 0);
    add(P, "s035_tnr_low", 0, 0, 0, 0, 8'h00, 0, 1, 0);
    add(G, "s035_gap0", 0, 0, 0, 0, 8'h00, 1, 1, 0);
    add(P, "s035_key1", 0, 0, 0, 0, 8'h02, 1, 1, 0);
    add(G, "s035_gap1", 0, 0, 0, 0, 8'h00, 1, 1, 0);
    add(P, "s035_key3", 0, 0, 0, 0, 8'h08, 1, 1, 0);
    add(G, "s035_gap2", 0, 0, 0, 0, 8'h00, 1, 1, 0);
    add(1, "s035_done", 0, 0, 0, 0, 8'h00, 1, 0, 1);
    add(1, "start_in_end_ignored", 0, 0, 1, 0, 8'h00, 1, 0, 0);
    add(2, "idle", 0, 0, 0, 0, 8'h00, 1, 0, 0);
    add(1, "abort_over_start", 0, 0, 1, 1, 8'h00, 1, 0, 0);
    add(1, "idle", 0, 0, 0, 0, 8'h00, 1, 0, 0);
    // Start pulse launches; a second pulse mid-PRESS must not disturb timing.
    add(1, "s037_start", 0, 0, 1, 0, 8'h00, 0, 1, 0);
    add(1, "s037_press", 0, 0, 0, 0, 8'h00, 0, 1, 0);
    add(1, "s037_restart_ignored", 0, 0, 1, 0, 8'h00, 0, 1, 0);
    add(P - 3, "s037_press", 0, 0, 0, 0, 8'h00, 0, 1, 0);
    add(G, "s037_gap0", 0, 0, 0, 0, 8'h00, 1, 1, 0);
    add(P, "s037_key1", 0, 0, 0, 0, 8'h02, 1, 1, 0);
    add(G, "s037_gap1", 0, 0, 0, 0, 8'h00, 1, 1, 0);
    add(P, "s037_key3", 0, 0, 0, 0, 8'h08, 1, 1, 0);
    add(G, "s037_gap2", 0, 0, 0, 0, 8'h00, 1, 1, 0);
    add(1, "s037_done", 0, 0, 0, 0, 8'h00, 1, 0, 1);
    add(2, "idle", 0, 0, 0, 0, 8'h00, 1, 0, 0);
    // Abort sampled at the end of the second key1 PRESS cycle.
    add(1, "s038_start", 0, 0, 1, 0, 8'h00, 0, 1, 0);
    add(P - 1, "s038_press", 0, 0, 0, 0, 8'h00, 0, 1, 0);
    add(G, "s038_gap", 0, 0, 0, 0, 8'h00, 1, 1, 0);
    add(2, "s038_key1", 0, 0, 0, 0, 8'h02, 1, 1, 0);
    add(1, "s038_abort", 0, 0, 0, 1, 8'h00, 1, 0, 0);
    add(4 * (P + G), "s038_no_done", 0, 0, 0, 0, 8'h00, 1, 0, 0);
    // Reset mid-GAP, then autostart replays from step 0.
    add(1, "s039_start", 0, 0, 1, 0, 8'h00, 0, 1, 0);
    add(P - 1, "s039_press", 0, 0, 0, 0, 8'h00, 0, 1, 0);
    add(1, "s039_gap", 0, 0, 0, 0, 8'h00, 1, 1, 0);
    add(2, "s039_reset", 0, 1, 0, 0, 8'h00, 0, 0, 0);
    add(P, "s039_restart", 0, 0, 0, 0, 8'h00, 0, 1, 0);
    add(G, "s039_gap0", 0, 0, 0, 0, 8'h00, 1, 1, 0);
    add(P, "s039_key1", 0, 0, 0, 0, 8'h02, 1, 1, 0);
    add(1, "s039_abort", 0, 0, 0, 1, 8'h00, 1, 0, 0);
    // No autostart, script {0,9}: key0, then a silent wait step, then done.
    add(2, "b_reset_hold", 1, 1, 0, 0, 8'h00, 0, 0, 0);
    add(2, "s031_tnr_release", 1, 0, 0, 0, 8'h00, 1, 0, 0);
    add(1, "s036_key0_start", 1, 0, 1, 0, 8'h01, 1, 1, 0);
    add(P - 1, "s036_key0", 1, 0, 0, 0, 8'h01, 1, 1, 0);
    add(G, "s036_gap0", 1, 0, 0, 0, 8'h00, 1, 1, 0);
    add(P + G, "s036_wait_step", 1, 0, 0, 0, 8'h00, 1, 1, 0);
    add(1, "s036_done", 1, 0, 0, 0, 8'h00, 1, 0, 1);
    add(2, "b_idle", 1, 0, 0, 0, 8'h00, 1, 0, 0);
`else
    // Looping script {2,FF}: key 04 every P+G+1 cycles with one done per pass.
    add(2, "c_reset_hold", 2, 1, 0, 0, 8'h00, 0, 0, 0);
    for (int pass = 0; pass < 2; pass++) begin
      add(P, "s040_key2", 2, 0, 0, 0, 8'h04, 1, 1, 0);
      add(G, "s040_gap", 2, 0, 0, 0, 8'h00, 1, 1, 0);
      add(1, "s040_done", 2, 0, 0, 0, 8'h00, 1, 0, 1);
    end
    add(P, "s040_key2", 2, 0, 0, 0, 8'h04, 1, 1, 0);
    add(1, "s040_abort", 2, 0, 0, 1, 8'h00, 1, 0, 0);
    add(3, "s040_stopped", 2, 0, 0, 0, 8'h00, 1, 0, 0);
`endif

    foreach (table_q[i]) begin
      @(negedge clk);
      reset = table_q[i].rst;
      start = table_q[i].st;
      abort = table_q[i].ab;
      sb.push_back(table_q[i]);
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
